// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry result FIFO with C/Z/N flag register.
// Each accepted result is queued with the flag values it produced.
// The carry flag feeds back to the ALU.
module alu_result_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] result_in,
  input  logic [2:0] czn_in,
  input  logic [1:0] op_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       flag_clr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] alu_out,
  output logic [2:0] out_czn,
  output logic       c_flag,
  output logic       z_flag,
  output logic       n_flag
);

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_AND  = 2'b01,
    OP_OR   = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  logic [10:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        c_q, z_q, n_q;
  logic        c_d, z_d, n_d;
  logic        accept;
  logic        pop;
  op_e         op;

  assign op        = op_e'(op_in);
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Next flag values; flag_clr overrides any update from an accept.
  always_comb begin
    c_d = c_q;
    z_d = z_q;
    n_d = n_q;
    if (flag_clr) begin
      c_d = 1'b0;
      z_d = 1'b0;
      n_d = 1'b0;
    end else if (accept) begin
      case (op)
        OP_ADD: begin
          c_d = czn_in[2];
          z_d = (result_in == 8'h00);
          n_d = result_in[7];
        end
        OP_AND, OP_OR: begin
          z_d = (result_in == 8'h00);
          n_d = result_in[7];
        end
        default: ;
      endcase
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= ~wr_ptr;
      if (pop)    rd_ptr <= ~rd_ptr;
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; each entry carries the post-update flag snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (accept) begin
      mem[wr_ptr] <= {result_in, c_d, z_d, n_d};
    end
  end

  // Flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= 1'b0;
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      c_q <= c_d;
      z_q <= z_d;
      n_q <= n_d;
    end
  end

  assign alu_out = mem[rd_ptr][10:3];
  assign out_czn = mem[rd_ptr][2:0];
  assign c_flag  = c_q;
  assign z_flag  = z_q;
  assign n_flag  = n_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage against a queue-based model.
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] result_in = '0;
  logic [2:0] czn_in = '0;
  logic [1:0] op_in = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flag_clr = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] alu_out;
  logic [2:0] out_czn;
  logic       c_flag, z_flag, n_flag;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Model: queue of {result, C, Z, N} entries plus current flags.
  logic [10:0] q[$];
  logic        mc, mz, mn;

  alu_result_stage dut (
    .clk(clk), .rst(rst), .result_in(result_in), .czn_in(czn_in),
    .op_in(op_in), .in_valid(in_valid), .in_ready(in_ready),
    .flag_clr(flag_clr), .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .out_czn(out_czn), .c_flag(c_flag),
    .z_flag(z_flag), .n_flag(n_flag)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic cycle(input logic iv, input logic [7:0] r, input logic [2:0] czn,
                       input logic [1:0] op, input logic ordy, input logic clr);
    logic acc, pp;
    in_valid = iv; result_in = r; czn_in = czn; op_in = op;
    out_ready = ordy; flag_clr = clr;
    acc = iv && (q.size() < 2);
    pp  = ordy && (q.size() > 0);
    @(posedge clk);
    if (clr) begin
      mc = 0; mz = 0; mn = 0;
    end else if (acc && op != 2'b11) begin
      mz = (r == 8'h00);
      mn = r[7];
      if (op == 2'b00) mc = czn[2];
    end
    if (pp) void'(q.pop_front());
    if (acc) q.push_back({r, mc, mz, mn});
    #1;
    in_valid = 1'b0; out_ready = 1'b0; flag_clr = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    mc = 0; mz = 0; mn = 0;
  endtask

  task automatic test_reset();
    logic [16:0] exp;
    rst = 1'b1;
    model_reset();
    #3;
    exp = {1'b0, 1'b1, 8'h00, 3'b000, 3'b000};
    n_cmp++;
    if ({out_valid, in_ready, alu_out, out_czn, c_flag, z_flag, n_flag} !== exp) begin
      n_err++;
      $display("FAIL reset: got %h expected %h",
               {out_valid, in_ready, alu_out, out_czn, c_flag, z_flag, n_flag}, exp);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_zero();
    logic [13:0] exp;
    cycle(1, 8'h00, 3'b100, 2'b00, 0, 0);
    exp = {1'b1, 8'h00, 3'b110, 1'b1, 1'b1};
    n_cmp++;
    if ({out_valid, alu_out, out_czn, c_flag, in_ready} !== exp) begin
      n_err++;
      $display("FAIL add_zero: got %h expected %h",
               {out_valid, alu_out, out_czn, c_flag, in_ready}, exp);
    end
    cycle(0, 8'h00, 3'b000, 2'b00, 1, 0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL add_zero_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_fill();
    cycle(0, 8'h00, 3'b000, 2'b00, 0, 1);
    cycle(1, 8'h81, 3'b111, 2'b01, 0, 0);
    cycle(1, 8'h7F, 3'b111, 2'b10, 0, 0);
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b01) begin
      n_err++;
      $display("FAIL fill_full: in_ready/out_valid got %b expected 01", {in_ready, out_valid});
    end
    cycle(1, 8'h05, 3'b100, 2'b00, 0, 0);
    n_cmp++;
    if ({in_ready, alu_out, out_czn, c_flag} !== {1'b0, 8'h81, 3'b001, 1'b0}) begin
      n_err++;
      $display("FAIL fill_blocked: got %h expected %h",
               {in_ready, alu_out, out_czn, c_flag}, {1'b0, 8'h81, 3'b001, 1'b0});
    end
    cycle(0, 8'h00, 3'b000, 2'b00, 1, 0);
    n_cmp++;
    if ({out_valid, in_ready, alu_out, out_czn} !== {1'b1, 1'b1, 8'h7F, 3'b000}) begin
      n_err++;
      $display("FAIL fill_second: got %h expected %h",
               {out_valid, in_ready, alu_out, out_czn}, {1'b1, 1'b1, 8'h7F, 3'b000});
    end
    cycle(0, 8'h00, 3'b000, 2'b00, 1, 0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fill_empty: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1, 8'h20, 3'b000, 2'b01, 0, 0);
    cycle(1, 8'h10, 3'b000, 2'b01, 1, 0);
    n_cmp++;
    if ({out_valid, in_ready, alu_out} !== {1'b1, 1'b1, 8'h10}) begin
      n_err++;
      $display("FAIL b2b_head: got %h expected %h",
               {out_valid, in_ready, alu_out}, {1'b1, 1'b1, 8'h10});
    end
    cycle(0, 8'h00, 3'b000, 2'b00, 1, 0);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_count: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_pass_op();
    cycle(1, 8'h01, 3'b100, 2'b00, 0, 0);
    cycle(0, 8'h00, 3'b000, 2'b00, 1, 0);
    cycle(1, 8'h00, 3'b011, 2'b11, 0, 0);
    n_cmp++;
    if ({c_flag, z_flag, n_flag, alu_out, out_czn} !== {3'b100, 8'h00, 3'b100}) begin
      n_err++;
      $display("FAIL pass_hold: got %h expected %h",
               {c_flag, z_flag, n_flag, alu_out, out_czn}, {3'b100, 8'h00, 3'b100});
    end
    cycle(0, 8'h00, 3'b000, 2'b00, 1, 0);
  endtask

  task automatic test_flag_clr();
    cycle(1, 8'hFF, 3'b100, 2'b00, 0, 1);
    n_cmp++;
    if ({c_flag, z_flag, n_flag, out_valid, alu_out, out_czn} !== {3'b000, 1'b1, 8'hFF, 3'b000}) begin
      n_err++;
      $display("FAIL flag_clr: got %h expected %h",
               {c_flag, z_flag, n_flag, out_valid, alu_out, out_czn}, {3'b000, 1'b1, 8'hFF, 3'b000});
    end
    cycle(0, 8'h00, 3'b000, 2'b00, 1, 0);
  endtask

  task automatic test_async_reset();
    cycle(1, 8'h91, 3'b100, 2'b00, 0, 0);
    cycle(1, 8'h92, 3'b100, 2'b00, 0, 0);
    #1 rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({out_valid, in_ready, c_flag, z_flag, n_flag, alu_out, out_czn} !==
        {1'b0, 1'b1, 3'b000, 8'h00, 3'b000}) begin
      n_err++;
      $display("FAIL async_reset: got %h expected %h",
               {out_valid, in_ready, c_flag, z_flag, n_flag, alu_out, out_czn},
               {1'b0, 1'b1, 3'b000, 8'h00, 3'b000});
    end
    #1 rst = 1'b0;
    cycle(1, 8'h33, 3'b000, 2'b01, 0, 0);
    n_cmp++;
    if ({out_valid, alu_out} !== {1'b1, 8'h33}) begin
      n_err++;
      $display("FAIL post_reset_accept: got %h expected %h", {out_valid, alu_out}, {1'b1, 8'h33});
    end
    cycle(0, 8'h00, 3'b000, 2'b00, 1, 0);
  endtask

  task automatic test_random();
    logic [16:0] got, exp;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom),
            2'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0));
      exp = {q.size() != 0, q.size() < 2, (q.size() != 0) ? q[0] : 11'h0, mc, mz, mn};
      got = {out_valid, in_ready, out_valid ? {alu_out, out_czn} : 11'h0, c_flag, z_flag, n_flag};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL random[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_zero();
    test_fill();
    test_back_to_back();
    test_pass_op();
    test_flag_clr();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk input 1 (rising edge), rst input 1 (asynchronous, active-high).
REQ-002 Port result_in, input, 8: ALU result byte.
REQ-003 Port czn_in, input, 3: ALU flag vector; bit 2 = carry, bits 1:0 ignored.
REQ-004 Port op_in, input, 2: opcode that produced result_in (00 ADD, 01 AND, 10 OR, 11 pass).
REQ-005 Port in_valid, input, 1: upstream presents a result this cycle.
REQ-006 Port in_ready, output, 1: stage can accept a result this cycle.
REQ-007 Port flag_clr, input, 1: synchronous clear of C/Z/N flags.
REQ-008 Port out_valid, output, 1: head entry available to writeback.
REQ-009 Port out_ready, input, 1: writeback consumes head entry this cycle.
REQ-010 Port alu_out, output, 8: head entry result byte.
REQ-011 Port out_czn, output, 3: flag snapshot {C,Z,N} stored with head entry.
REQ-012 Port c_flag, output, 1: current carry flag, fed back to the ALU carry input.
REQ-013 Ports z_flag and n_flag, output, 1 each: current zero and negative flags.

Function
REQ-014 Storage SHALL be a 2-entry FIFO of {result[7:0], czn[2:0]}; an occupancy count 0..2 and 1-bit read/write pointers SHALL wrap modulo 2.
REQ-015 Accept occurs when in_valid && in_ready; pop occurs when out_valid && out_ready; both take effect on the same rising clk edge.
REQ-016 in_ready SHALL be 1 when count < 2 and 0 when count == 2, regardless of out_ready (no combinational ready-through).
REQ-017 out_valid SHALL be 1 exactly when count != 0; alu_out and out_czn SHALL show the head entry and be don't-care when out_valid = 0.
REQ-018 Latency: a result accepted at edge N into an empty FIFO SHALL appear with out_valid = 1 in the cycle following edge N.
REQ-019 Simultaneous accept and pop at count 1 SHALL leave count at 1, with the new entry at head after the edge.
REQ-020 Pop at count 0 and accept at count 2 SHALL be impossible by construction; state SHALL not change for them.
REQ-021 Flag update on accept: Z = (result_in == 8'h00), N = result_in[7]; czn_in[1:0] SHALL NOT be used.
REQ-022 On accept with op_in 00, C SHALL load czn_in[2]; with op_in 01 or 10, C SHALL hold; Z and N SHALL load per REQ-021.
REQ-023 On accept with op_in 11, C, Z and N SHALL all hold; the result is queued unchanged.
REQ-024 The stored out_czn of an accepted entry SHALL equal the flag values after that entry's update.
REQ-025 flag_clr asserted SHALL clear C, Z and N at the edge and SHALL win over a simultaneous accept's flag update; the accepted entry SHALL still be queued with out_czn = 3'b000.
REQ-026 c_flag, z_flag and n_flag SHALL be registered outputs, changing only on rising clk or rst.

Reset
REQ-027 While rst = 1: count = 0, both pointers = 0, C = Z = N = 0, in_ready = 1, out_valid = 0, alu_out = 8'h00, out_czn = 3'b000.
REQ-028 Reset asserted mid-operation SHALL discard all queued entries immediately (asynchronously), without waiting for a clock.
REQ-029 The first accept SHALL be possible on the first rising clk after rst deasserts.

Verification
REQ-030 Reset then ADD result 8'h00, czn_in 3'b100, out_ready = 0 -> next cycle out_valid = 1, alu_out = 8'h00, out_czn = 3'b110, c_flag = 1.
REQ-031 Fill: accept 8'h81 (AND) then 8'h7F (OR) with out_ready = 0 -> in_ready = 0 at count 2; in_valid held with 8'h05 is not accepted; entries then drain in order 8'h81 (out_czn 3'b001, C held at 0) then 8'h7F (3'b000).
REQ-032 Count 1, simultaneous accept 8'h10 and pop -> count stays 1; the next head is 8'h10.
REQ-033 ADD sets C = 1, then op 11 with 8'h00 accepted -> C, Z, N unchanged (1, 0, 0); alu_out = 8'h00.
REQ-034 flag_clr together with ADD 8'hFF, czn_in 3'b100 -> flags 000; entry 8'hFF queued with out_czn 3'b000.
REQ-035 rst pulsed between clock edges with 2 entries queued -> out_valid = 0 and in_ready = 1 before the next edge; flags = 000.
